// File: rtl/frame_pkg.sv
// Shared types and constants for the frame serializer.
package frame_pkg;

    localparam int unsigned ADDR_SIZE_DEFAULT = 8;
    localparam logic [7:0]  HEADER_DEFAULT    = 8'hA5;

    // Number of samples in one frame for a given address width.
    function automatic int unsigned samples_per_frame(input int unsigned addr_size);
        return 32'(1) << addr_size;
    endfunction

    localparam int unsigned SAMPLES_PER_FRAME = samples_per_frame(ADDR_SIZE_DEFAULT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_REQ,
        S_WAIT_S,
        S_SEND_HI,
        S_SEND_LO,
        S_CHECKSUM,
        S_WAIT_SWAP
    } state_t;

    typedef enum logic [2:0] {
        G_IDLE,
        G_WAIT,
        G_PULSE,
        G_HOLD,
        G_DRAIN
    } gate_state_t;

endpackage

// File: rtl/frame_serializer_tx_byte_gate.sv
// Hands one byte to the transmitter: waits for it to be free, pulses
// new_tx_data, ignores the late busy for one cycle, then waits for idle.
module tx_byte_gate
    import frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] start_byte,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    output logic       done
);

    gate_state_t state, state_next;
    logic [7:0]  byte_q, byte_next;
    logic [7:0]  tx_data_next;
    logic        new_tx_data_next;
    logic        done_next;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= G_IDLE;
            byte_q      <= '0;
            tx_data     <= '0;
            new_tx_data <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            byte_q      <= byte_next;
            tx_data     <= tx_data_next;
            new_tx_data <= new_tx_data_next;
            done        <= done_next;
        end
    end

    // Next-state logic; PULSE and HOLD both ignore tx_busy because the
    // transmitter only raises it a cycle after seeing the strobe.
    always_comb begin
        state_next       = state;
        byte_next        = byte_q;
        tx_data_next     = tx_data;
        new_tx_data_next = 1'b0;
        done_next        = 1'b0;
        case (state)
            G_IDLE: begin
                if (start) begin
                    byte_next  = start_byte;
                    state_next = G_WAIT;
                end
            end
            G_WAIT: begin
                if (!tx_busy) begin
                    tx_data_next     = byte_q;
                    new_tx_data_next = 1'b1;
                    state_next       = G_PULSE;
                end
            end
            G_PULSE: state_next = G_HOLD;
            G_HOLD:  state_next = G_DRAIN;
            G_DRAIN: begin
                if (!tx_busy) begin
                    done_next  = 1'b1;
                    state_next = G_IDLE;
                end
            end
            default: state_next = G_IDLE;
        endcase
    end

endmodule

// File: rtl/frame_serializer.sv
// Reads one frame from the ping-pong buffer and sends it as
// header, samples MSB first, then an 8-bit checksum.
module frame_serializer
    import frame_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEFAULT,
    parameter logic [7:0]  HEADER    = HEADER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] sample_in,
    input  logic        new_sample_in,
    input  logic        frame_end,
    output logic        read_ready,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    output logic        busy
);

    localparam int unsigned           SAMPLES    = samples_per_frame(ADDR_SIZE);
    localparam logic [ADDR_SIZE-1:0]  LAST_INDEX = ADDR_SIZE'(SAMPLES - 1);

    state_t               state, state_next;
    logic [ADDR_SIZE-1:0] cnt, cnt_next;
    logic [7:0]           csum, csum_next;
    logic [15:0]          sample_q, sample_next;
    logic                 busy_next;
    logic                 read_ready_next;
    logic                 seen, seen_next;
    logic                 start_c;
    logic [7:0]           start_byte_c;
    logic                 done;

    tx_byte_gate u_gate (
        .clk         (clk),
        .rst         (rst),
        .start       (start_c),
        .start_byte  (start_byte_c),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .done        (done)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            csum       <= '0;
            sample_q   <= '0;
            busy       <= 1'b0;
            read_ready <= 1'b0;
            seen       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            csum       <= csum_next;
            sample_q   <= sample_next;
            busy       <= busy_next;
            read_ready <= read_ready_next;
            seen       <= seen_next;
        end
    end

    // Packet sequencing; each byte is launched on the transition into its
    // send state so the gate sees exactly one start per byte.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        csum_next       = csum;
        sample_next     = sample_q;
        busy_next       = busy;
        read_ready_next = 1'b0;
        seen_next       = seen;
        start_c         = 1'b0;
        start_byte_c    = '0;
        case (state)
            S_IDLE: begin
                if (enable && !frame_end) begin
                    cnt_next     = '0;
                    csum_next    = '0;
                    busy_next    = 1'b1;
                    start_c      = 1'b1;
                    start_byte_c = HEADER;
                    state_next   = S_HEADER;
                end
            end
            S_HEADER: begin
                if (done) state_next = S_REQ;
            end
            S_REQ: begin
                // A drained buffer here means the frame was short: stop reading.
                if (frame_end) begin
                    start_c      = 1'b1;
                    start_byte_c = csum;
                    state_next   = S_CHECKSUM;
                end else begin
                    read_ready_next = 1'b1;
                    state_next      = S_WAIT_S;
                end
            end
            S_WAIT_S: begin
                if (new_sample_in) begin
                    sample_next  = sample_in;
                    start_c      = 1'b1;
                    start_byte_c = sample_in[15:8];
                    csum_next    = csum + sample_in[15:8];
                    state_next   = S_SEND_HI;
                end else if (frame_end) begin
                    start_c      = 1'b1;
                    start_byte_c = csum;
                    state_next   = S_CHECKSUM;
                end
            end
            S_SEND_HI: begin
                if (done) begin
                    start_c      = 1'b1;
                    start_byte_c = sample_q[7:0];
                    csum_next    = csum + sample_q[7:0];
                    state_next   = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (done) begin
                    if (cnt == LAST_INDEX) begin
                        start_c      = 1'b1;
                        start_byte_c = csum;
                        state_next   = S_CHECKSUM;
                    end else begin
                        cnt_next   = cnt + ADDR_SIZE'(1);
                        state_next = S_REQ;
                    end
                end
            end
            S_CHECKSUM: begin
                if (done) begin
                    busy_next  = 1'b0;
                    seen_next  = 1'b0;
                    state_next = S_WAIT_SWAP;
                end
            end
            S_WAIT_SWAP: begin
                // Need a high then a low on frame_end: buffer swapped in a new frame.
                if (frame_end) begin
                    seen_next = 1'b1;
                end else if (seen) begin
                    seen_next  = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer with a frame buffer model
// (configurable latency) and a transmitter busy for 10 cycles per byte.
module tb_frame_serializer;
    import frame_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] sample_in = '0;
    logic        new_sample_in = 1'b0;
    logic        frame_end = 1'b0;
    logic        read_ready;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy;
    logic        busy;

    frame_serializer #(.ADDR_SIZE(2), .HEADER(8'hA5)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .sample_in     (sample_in),
        .new_sample_in (new_sample_in),
        .frame_end     (frame_end),
        .read_ready    (read_ready),
        .tx_data       (tx_data),
        .new_tx_data   (new_tx_data),
        .tx_busy       (tx_busy),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Frame buffer model
    logic [15:0] mem [4];
    int          lat       = 1;
    int          err_after = 0;
    logic        swap_req  = 1'b0;
    int          idx  = 0;
    int          pend = 0;
    logic        go;

    assign go = !rst && !swap_req && (read_ready ? (lat <= 1) : (pend == 1));

    always @(posedge clk) begin
        new_sample_in <= 1'b0;
        if (rst || swap_req) begin
            idx       <= 0;
            pend      <= 0;
            frame_end <= 1'b0;
        end else begin
            if (read_ready) begin
                if (lat > 1) pend <= lat - 1;
            end else if (pend != 0) begin
                pend <= pend - 1;
            end
            if (go) begin
                new_sample_in <= 1'b1;
                sample_in     <= (idx < 4) ? mem[idx] : 16'hDEAD;
                idx           <= idx + 1;
                if (idx == 3 || (err_after != 0 && idx + 1 == err_after)) frame_end <= 1'b1;
            end
        end
    end

    // Transmitter model: busy rises one cycle late and lasts 10 cycles.
    logic [7:0] log_mem [256];
    int         n_bytes = 0;
    int         tx_viol = 0;
    logic       arm     = 1'b0;
    int         tx_cnt  = 0;

    assign tx_busy = (tx_cnt != 0);

    always @(posedge clk) begin
        if (new_tx_data) begin
            if (n_bytes < 256) log_mem[n_bytes] <= tx_data;
            n_bytes <= n_bytes + 1;
            if (tx_busy) tx_viol <= tx_viol + 1;
        end
        arm <= new_tx_data;
        if (arm) tx_cnt <= 10;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end

    // Read handshake monitor: pulse width and one-outstanding rule.
    int   rr_cnt  = 0;
    int   rr_viol = 0;
    logic rr_prev = 1'b0;
    logic outstanding = 1'b0;

    always @(posedge clk) begin
        rr_prev <= read_ready;
        if (rst) begin
            outstanding <= 1'b0;
        end else if (read_ready) begin
            rr_cnt <= rr_cnt + 1;
            if (rr_prev || outstanding) rr_viol <= rr_viol + 1;
            outstanding <= 1'b1;
        end else if (new_sample_in) begin
            outstanding <= 1'b0;
        end
    end

    logic [7:0] exp_q [$];

    task automatic wait_bytes(input int target, input int budget);
        for (int i = 0; i < budget && n_bytes < target; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_busy_low(input int budget);
        for (int i = 0; i < budget && busy; i++) begin
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        @(posedge clk); #1;
        swap_req = 1'b0;
    endtask

    task automatic expect_packet(input string tag, input int start);
        check({tag, "_len"}, 32'(n_bytes - start), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 32'(log_mem[start + i]), 32'(exp_q[i]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rr"},    32'(read_ready),  32'(0));
        check({tag, "_ntx"},   32'(new_tx_data), 32'(0));
        check({tag, "_txd"},   32'(tx_data),     32'(0));
        check({tag, "_busy"},  32'(busy),        32'(0));
        check({tag, "_state"}, 32'(dut.state),   32'(S_IDLE));
    endtask

    task automatic load_frame_a();
        mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0001; mem[3] = 16'hFFFF;
    endtask

    int start;
    int rr0;
    int b0;

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        load_frame_a();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst    = 1'b0;
        enable = 1'b1;

        // Basic frame, latency 1
        start = n_bytes; rr0 = rr_cnt;
        exp_q = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hBD};
        wait_bytes(start + 10, 2000);
        expect_packet("basic", start);
        wait_busy_low(200);
        check("basic_rr_pulses", 32'(rr_cnt - rr0), 32'(4));
        check("basic_busy", 32'(busy), 32'(0));
        check("basic_state", 32'(dut.state), 32'(S_WAIT_SWAP));

        // Buffer latency 5
        lat = 5;
        start = n_bytes; rr0 = rr_cnt;
        do_swap();
        wait_bytes(start + 10, 3000);
        expect_packet("lat5", start);
        wait_busy_low(200);
        check("lat5_rr_pulses", 32'(rr_cnt - rr0), 32'(4));
        check("lat5_rr_viol", 32'(rr_viol), 32'(0));

        // All-zero frame
        lat = 1;
        mem[0] = '0; mem[1] = '0; mem[2] = '0; mem[3] = '0;
        start = n_bytes;
        do_swap();
        exp_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        wait_bytes(start + 10, 2000);
        expect_packet("zero", start);
        wait_busy_low(200);

        // enable dropped after the header
        load_frame_a();
        start = n_bytes;
        do_swap();
        wait_bytes(start + 1, 500);
        enable = 1'b0;
        exp_q = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hBD};
        wait_bytes(start + 10, 2000);
        expect_packet("endrop", start);
        wait_busy_low(200);
        do_swap();
        rr0 = rr_cnt; b0 = n_bytes;
        repeat (60) @(posedge clk);
        #1;
        check("endrop_idle_rr", 32'(rr_cnt - rr0), 32'(0));
        check("endrop_idle_bytes", 32'(n_bytes - b0), 32'(0));
        check("endrop_idle_busy", 32'(busy), 32'(0));
        check("endrop_idle_state", 32'(dut.state), 32'(S_IDLE));

        // frame_end arrives with the second sample: short packet
        err_after = 2;
        start = n_bytes; rr0 = rr_cnt;
        enable = 1'b1;
        exp_q = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        wait_bytes(start + 6, 2000);
        wait_busy_low(200);
        repeat (40) @(posedge clk);
        #1;
        expect_packet("short", start);
        check("short_rr_pulses", 32'(rr_cnt - rr0), 32'(2));
        check("short_state", 32'(dut.state), 32'(S_WAIT_SWAP));
        check("short_busy", 32'(busy), 32'(0));

        // Reset in the middle of SEND_LO
        err_after = 0;
        do_swap();
        for (int i = 0; i < 2000 && dut.state != S_SEND_LO; i++) begin
            @(posedge clk); #1;
        end
        check("rst_reached_send_lo", 32'(dut.state), 32'(S_SEND_LO));
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        start = n_bytes;
        exp_q = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hBD};
        wait_bytes(start + 10, 2000);
        expect_packet("afterrst", start);
        wait_busy_low(200);

        check("rr_protocol_viol", 32'(rr_viol), 32'(0));
        check("tx_busy_viol", 32'(tx_viol), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
